// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: instruction-fetch front end feeding the IF/ID register.
// Issues one word fetch at a time over a req/ack handshake, buffers returned
// words with their PCs in a small FIFO, and presents the head to decode.
// Branch/jump redirects flush the queue; a request already in flight is
// allowed to complete and its data is dropped.
// Optional feature: define FETCH_PFQ_BYPASS_EN to forward an ack straight to
// the outputs when the queue is empty (zero-cycle ack-to-output latency).
module fetch_prefetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic        valid_o,
  output logic        busy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          mem_req_q, mem_req_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] pc_mem_q    [DEPTH];
  logic [31:0] instr_mem_q [DEPTH];

  logic fifo_valid;
  logic ack_ok;
  logic bypass_hit;
  logic bypass_take;
  logic push;
  logic pop;

  assign fifo_valid = (count_q != '0);
  // An accepted response is one completing a live (non-dropped) request with no redirect.
  assign ack_ok     = (state_q == ST_REQ) && mem_ack && !redirect_i;

`ifdef FETCH_PFQ_BYPASS_EN
  assign bypass_hit = ack_ok && (count_q == '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign bypass_take = bypass_hit && !stall_i;
  assign push        = ack_ok && !bypass_take;
  assign pop         = fifo_valid && !stall_i && !redirect_i;

  // Fetch state machine: issues a request only when a slot is free, holds it until ack.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end else if (count_q < DEPTH_C) begin
          state_d    = ST_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
        end
      end
      ST_REQ: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
          if (mem_ack) begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end else if (mem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
        end
      end
      ST_DROP: begin
        if (redirect_i) begin
          fetch_pc_d = redirect_pc_i;
        end
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // FIFO bookkeeping: a redirect flushes everything; otherwise push/pop move the pointers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and pointer registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Queue storage needs no reset; count_q decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata;
    end
  end

  // Head selection: queue head, NOP bubble when empty, or the forwarded ack word.
  always_comb begin
    valid_o = fifo_valid;
    instr_o = NOP_INSTR;
    pc_o    = '0;
    if (fifo_valid) begin
      instr_o = instr_mem_q[rd_ptr_q];
      pc_o    = pc_mem_q[rd_ptr_q];
    end
`ifdef FETCH_PFQ_BYPASS_EN
    if (bypass_hit) begin
      valid_o = 1'b1;
      instr_o = mem_rdata;
      pc_o    = fetch_pc_q;
    end
`endif
  end

  assign pcplus4_o = pc_o + 32'd4;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign busy_o    = (state_q != ST_IDLE);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst) push |-> (count_q != DEPTH_C));

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined datapath's IF/ID register.
- Issues word fetches to a variable-latency instruction memory over a req/ack handshake and buffers returned words in a small FIFO.
- Presents instruction, PC and PC+4 to the decode register; honours StallF and the EX-stage branch/jump redirect (PCSrcE/PCTargetE).
- Outputs a NOP bubble when nothing valid is available.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >= 2)
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction driven when valid_o=0 (addi x0,x0,0)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- mem_req  output  1  fetch request to instruction memory
- mem_addr  output  32  fetch word address
- mem_ack  input  1  response valid; completes the outstanding request
- mem_rdata  input  32  returned instruction word
- stall_i  input  1  StallF from hazard unit; 1 = consumer does not take the head this cycle
- redirect_i  input  1  PCSrcE; taken branch or jump
- redirect_pc_i  input  32  PCTargetE
- instr_o  output  32  head instruction, or NOP_INSTR when empty
- pc_o  output  32  PC of head entry
- pcplus4_o  output  32  pc_o + 4
- valid_o  output  1  head entry valid
- busy_o  output  1  request outstanding (state != IDLE)

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; FIFO empty; state=IDLE; mem_req=0; mem_addr=RESET_PC; valid_o=0; instr_o=NOP_INSTR; pc_o=0; pcplus4_o=4; busy_o=0.
- Each FIFO entry stores {pc, instr}. count ranges 0..DEPTH. Pointers wrap modulo DEPTH.
- Pop occurs when valid_o & ~stall_i & ~redirect_i, at the clock edge.
- State machine states: IDLE, REQ, DROP.
- IDLE -> REQ when (count + 0) < DEPTH and ~redirect_i.
  - Registered outputs: mem_req=1, mem_addr=fetch_pc.
  - Slot reservation: at most one request is outstanding, and issue is allowed only if a free slot exists at issue time, counting the reserved slot.
- REQ handshake: mem_req and mem_addr are held stable until mem_ack is sampled high.
- REQ, mem_ack=1, no redirect:
  - Push {fetch_pc, mem_rdata}; fetch_pc += 4; mem_req drops for one cycle.
  - State -> IDLE. Re-issue can occur next cycle, giving a minimum of 2 cycles per fetch.
- Ack-to-visibility latency: data acked in cycle N is visible on instr_o/valid_o in cycle N+1.
- Redirect (highest priority, any state):
  - FIFO flushed (count=0, pointers reset); fetch_pc=redirect_pc_i; no pop that cycle; valid_o=0 next cycle.
  - In REQ with mem_ack=0: state -> DROP, mem_req stays high (the request must complete).
  - In REQ with mem_ack=1 in the same cycle: the response is discarded and state -> IDLE.
- DROP: wait for mem_ack, discard the data, -> IDLE. A further redirect in DROP only updates fetch_pc and stays in DROP.
- Same-edge push and pop: both are allowed and count is unchanged. Push into a full FIFO is impossible by construction; an assertion flags it.
- stall_i=1: head held and outputs stable; fetching continues until the FIFO is full.
- Address arithmetic is 32-bit and wraps at 2^32 without a flag. Bits [1:0] of fetch_pc pass through unchanged; alignment is the producer's responsibility.
- rst asserted mid-request: returns to reset state immediately. A late mem_ack arriving after rst deasserts must be ignored; the state is IDLE, so it is ignored.

Optional Feature:
- Macro: FETCH_PFQ_BYPASS_EN.
- Defined: when count=0, state=REQ, mem_ack=1 and no redirect:
  - instr_o=mem_rdata, pc_o=fetch_pc and valid_o=1 combinationally in the same cycle.
  - If ~stall_i the word is consumed and not pushed; otherwise it is pushed as normal.
  - Ack-to-output latency is 0 cycles.
- Undefined: no combinational path from mem_ack/mem_rdata to the outputs; latency is 1 cycle as above.

Test Plan:
- Reset then zero-wait memory (ack the cycle after req), stall_i=0 -> mem_addr sequence 0,4,8,...; pc_o/instr_o follow one cycle after each ack; pcplus4_o=pc_o+4.
- stall_i=1 held 20 cycles with immediate acks -> exactly DEPTH=4 entries fetched (0x0..0xC), mem_req stays 0 after that, pc_o=0 stable; release -> pops 0,4,8,C in order.
- 3-cycle-latency memory, redirect_i=1 to 0x100 while REQ for 0x8 is pending -> state DROP, 0x8 data discarded, next mem_addr=0x100, first valid pc_o=0x100.
- redirect_i=1 to 0x40 in the same cycle as mem_ack for 0x10 -> 0x10 word never appears on instr_o; valid_o=0 next cycle; next fetch 0x40.
- Assert rst=0 mid-REQ at pc 0x24 -> outputs immediately at reset values; after release the first mem_addr=RESET_PC.
- With FETCH_PFQ_BYPASS_EN, empty FIFO, ack of 0xDEADBEEF at pc 0x0 with stall_i=0 -> instr_o=0xDEADBEEF and valid_o=1 in the ack cycle; count stays 0.
